// File: rtl/shift_readout_sequencer.sv
// Readout scheduler for the shift-chain error counters. It snapshots the counters, then
// frames a sync/frame-number header, the serialized payload and an even-parity trailer.
//
// state   | meaning
// IDLE    | waiting for a manual request or a periodic tick
// SNAP    | snapshot strobe to the serializer, header word captured
// HEADER  | 16 header bits {SYNC_WORD, frame number}, MSB first
// PAYLOAD | serializer bits passed straight through to TX_DATA
// TRAILER | parity bit sent, frame number advanced
module shift_readout_sequencer #(
  parameter int         NUM_CHAINS  = 4,
  parameter int         CNT_WIDTH   = 16,
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         SER_LATENCY = 1,
  parameter int         INT_WIDTH   = 24
) (
  input  logic                 DATA_CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [INT_WIDTH-1:0] INTERVAL,
  input  logic                 READ_REQ,
  input  logic                 CLR_OVERRUN,
  input  logic                 SER_DATA,
  output logic                 SAVE_DATA,
  output logic                 SER_RST,
  output logic                 TX_DATA,
  output logic                 TX_VALID,
  output logic                 FRAME_START,
  output logic                 FRAME_END,
  output logic                 BUSY,
  output logic [7:0]           FRAME_NUM,
  output logic                 OVERRUN
);

  localparam int PAY_LEN = NUM_CHAINS * CNT_WIDTH;
  localparam int CW      = $clog2((PAY_LEN > 16) ? PAY_LEN : 16);

  localparam logic [CW-1:0]        HDR_LAST = CW'(15);
  localparam logic [CW-1:0]        PAY_LAST = CW'(PAY_LEN - 1);
  localparam logic [CW-1:0]        LAT_C    = CW'(SER_LATENCY);
  localparam logic [CW-1:0]        ONE_C    = CW'(1);
  localparam logic [INT_WIDTH-1:0] ONE_I    = INT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    HEADER,
    PAYLOAD,
    TRAILER
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [15:0]          hdr;
  logic                 parity;
  logic [INT_WIDTH-1:0] icnt;
  logic                 int_en;
  logic                 tick;
  logic                 trigger;
  logic                 tx_data_c;

  assign int_en  = ENABLE && (INTERVAL != '0);
  // >= rather than == so a shrinking INTERVAL wraps at the next compare instead of rolling over
  assign tick    = int_en && (icnt >= (INTERVAL - ONE_I));
  assign trigger = READ_REQ | tick;

  always_ff @(posedge DATA_CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      hdr         <= '0;
      parity      <= 1'b0;
      icnt        <= '0;
      SAVE_DATA   <= 1'b0;
      SER_RST     <= 1'b1;
      TX_VALID    <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_NUM   <= '0;
      OVERRUN     <= 1'b0;
    end else begin
      if (!int_en || tick) begin
        icnt <= '0;
      end else begin
        icnt <= icnt + ONE_I;
      end

      if (trigger && (state != IDLE)) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVERRUN) begin
        OVERRUN <= 1'b0;
      end

      SAVE_DATA   <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;

      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= SNAP;
            SAVE_DATA <= 1'b1;
            BUSY      <= 1'b1;
            hdr       <= {SYNC_WORD, FRAME_NUM};
            parity    <= 1'b0;
          end
        end
        SNAP: begin
          state       <= HEADER;
          cnt         <= HDR_LAST;
          TX_VALID    <= 1'b1;
          FRAME_START <= 1'b1;
          SER_RST     <= (HDR_LAST >= LAT_C);
        end
        HEADER: begin
          // serializer leaves reset SER_LATENCY cycles before the first payload bit
          if (cnt == '0) begin
            state   <= PAYLOAD;
            cnt     <= PAY_LAST;
            SER_RST <= 1'b0;
          end else begin
            cnt     <= cnt - ONE_C;
            SER_RST <= ((cnt - ONE_C) >= LAT_C);
          end
        end
        PAYLOAD: begin
          parity <= parity ^ SER_DATA;
          if (cnt == '0) begin
            state     <= TRAILER;
            FRAME_END <= 1'b1;
            SER_RST   <= 1'b1;
          end else begin
            cnt <= cnt - ONE_C;
          end
        end
        TRAILER: begin
          state     <= IDLE;
          BUSY      <= 1'b0;
          TX_VALID  <= 1'b0;
          FRAME_NUM <= FRAME_NUM + 8'd1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tx_data_c = 1'b0;
    case (state)
      HEADER:  tx_data_c = hdr[cnt[3:0]];
      PAYLOAD: tx_data_c = SER_DATA;
      TRAILER: tx_data_c = parity;
      default: tx_data_c = 1'b0;
    endcase
  end

  assign TX_DATA = tx_data_c;

endmodule

// File: tb/tb_shift_readout_sequencer.sv
// Scoreboard bench for shift_readout_sequencer: two instances (serializer latency 1 and 3)
// each fed by a serializer model; expected frames are queued when triggers are driven.
module tb_shift_readout_sequencer;

  typedef struct {
    int          inst;
    logic [15:0] hdr;
    logic [63:0] pay;
    logic        par;
    int          start;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst[2], enable[2], read_req[2], clr_overrun[2], ser_data[2];
  logic [23:0] interval[2];
  logic        save_data[2], ser_rst[2], tx_data[2], tx_valid[2];
  logic        frame_start[2], frame_end[2], busy[2], overrun[2];
  logic [7:0]  frame_num[2];

  shift_readout_sequencer #(.SER_LATENCY(1)) dut (
    .DATA_CLK(clk), .RST(rst[0]), .ENABLE(enable[0]), .INTERVAL(interval[0]),
    .READ_REQ(read_req[0]), .CLR_OVERRUN(clr_overrun[0]), .SER_DATA(ser_data[0]),
    .SAVE_DATA(save_data[0]), .SER_RST(ser_rst[0]), .TX_DATA(tx_data[0]),
    .TX_VALID(tx_valid[0]), .FRAME_START(frame_start[0]), .FRAME_END(frame_end[0]),
    .BUSY(busy[0]), .FRAME_NUM(frame_num[0]), .OVERRUN(overrun[0])
  );

  shift_readout_sequencer #(.SER_LATENCY(3)) dut3 (
    .DATA_CLK(clk), .RST(rst[1]), .ENABLE(enable[1]), .INTERVAL(interval[1]),
    .READ_REQ(read_req[1]), .CLR_OVERRUN(clr_overrun[1]), .SER_DATA(ser_data[1]),
    .SAVE_DATA(save_data[1]), .SER_RST(ser_rst[1]), .TX_DATA(tx_data[1]),
    .TX_VALID(tx_valid[1]), .FRAME_START(frame_start[1]), .FRAME_END(frame_end[1]),
    .BUSY(busy[1]), .FRAME_NUM(frame_num[1]), .OVERRUN(overrun[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Serializer model: first payload bit appears SER_LATENCY cycles after reset release
  int          low_cnt[2];
  logic [63:0] pattern[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) low_cnt[i] <= (ser_rst[i] !== 1'b0) ? 0 : low_cnt[i] + 1;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ser_data[i] = 1'b0;
      if (low_cnt[i] >= lat(i) && low_cnt[i] < lat(i) + 64)
        ser_data[i] = pattern[i][63 - (low_cnt[i] - lat(i))];
    end
  end

  frame_t     exp_q[$];
  logic [7:0] fn_model[2];

  task automatic push_frame(input int inst, input int start);
    frame_t f;
    f.inst  = inst;
    f.hdr   = {8'hA5, fn_model[inst]};
    f.pay   = pattern[inst];
    f.par   = ^pattern[inst];
    f.start = start;
    exp_q.push_back(f);
    fn_model[inst] = fn_model[inst] + 8'd1;
  endtask

  // Monitor: collects each framed transmission and checks it against the queue
  int          mon_idx[2]   = '{-1, -1};
  int          mon_start[2];
  int          save_cyc[2];
  int          fall_cyc[2];
  logic        ser_rst_d[2] = '{1'b1, 1'b1};
  logic [15:0] mon_hdr[2];
  logic [63:0] mon_pay[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (save_data[i] === 1'b1) save_cyc[i] = cyc;
      if (ser_rst_d[i] === 1'b1 && ser_rst[i] === 1'b0) fall_cyc[i] = cyc;
      ser_rst_d[i] = ser_rst[i];
      if (rst[i]) begin
        mon_idx[i] = -1;
      end else begin
        if (frame_start[i] === 1'b1) begin
          check_eq("save_lead", 64'(cyc - save_cyc[i]), 64'd1);
          mon_idx[i]   = 0;
          mon_start[i] = cyc;
        end
        if (mon_idx[i] < 0) begin
          check_eq("idle_tx_valid", 64'(tx_valid[i]), 64'd0);
          check_eq("idle_tx_data", 64'(tx_data[i]), 64'd0);
        end else begin
          check_eq("frame_tx_valid", 64'(tx_valid[i]), 64'd1);
          if (mon_idx[i] < 16) begin
            mon_hdr[i] = {mon_hdr[i][14:0], tx_data[i]};
            mon_idx[i]++;
          end else if (mon_idx[i] < 80) begin
            mon_pay[i] = {mon_pay[i][62:0], tx_data[i]};
            mon_idx[i]++;
          end else begin
            check_eq("trailer_frame_end", 64'(frame_end[i]), 64'd1);
            check_eq("trailer_ser_rst", 64'(ser_rst[i]), 64'd1);
            check_eq("trailer_busy", 64'(busy[i]), 64'd1);
            if (exp_q.size() == 0) begin
              check_eq("unexpected_frame", 64'd1, 64'd0);
            end else begin
              frame_t e;
              e = exp_q.pop_front();
              check_eq("frame_inst", 64'(i), 64'(e.inst));
              check_eq("header", 64'(mon_hdr[i]), 64'(e.hdr));
              check_eq("payload", mon_pay[i], e.pay);
              check_eq("parity", 64'(tx_data[i]), 64'(e.par));
              check_eq("frame_start_cyc", 64'(mon_start[i]), 64'(e.start));
              check_eq("ser_rst_fall_cyc", 64'(fall_cyc[i]), 64'(e.start + 16 - lat(i)));
            end
            mon_idx[i] = -1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic manual_frame(input int inst, output int k);
    k = cyc;
    read_req[inst] = 1'b1;
    push_frame(inst, k + 2);
    step();
    read_req[inst] = 1'b0;
  endtask

  task automatic reset_inst(input int inst);
    rst[inst] = 1'b1;
    step();
    rst[inst] = 1'b0;
    fn_model[inst] = 8'd0;
  endtask

  initial begin
    int k, k2, n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; enable[i] = 1'b0; read_req[i] = 1'b0; clr_overrun[i] = 1'b0;
      interval[i] = '0; pattern[i] = '0; fn_model[i] = 8'd0;
    end
    step();
    step();
    check_eq("rst_ser_rst", 64'(ser_rst[0]), 64'd1);
    check_eq("rst_save_data", 64'(save_data[0]), 64'd0);
    check_eq("rst_tx_valid", 64'(tx_valid[0]), 64'd0);
    check_eq("rst_busy", 64'(busy[0]), 64'd0);
    check_eq("rst_frame_num", 64'(frame_num[0]), 64'd0);
    check_eq("rst_overrun", 64'(overrun[0]), 64'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Manual frame
    pattern[0] = 64'h0001_8000_FFFF_00F0;
    manual_frame(0, k);
    check_eq("snap_save_data", 64'(save_data[0]), 64'd1);
    check_eq("snap_busy", 64'(busy[0]), 64'd1);
    check_eq("snap_tx_valid", 64'(tx_valid[0]), 64'd0);
    check_eq("snap_ser_rst", 64'(ser_rst[0]), 64'd1);
    wait_until(k + 83);
    check_eq("manual_busy_low", 64'(busy[0]), 64'd0);
    check_eq("manual_frame_num", 64'(frame_num[0]), 64'd1);

    // Trigger on trailer is dropped, trigger on the first idle cycle is accepted
    pattern[0] = 64'h1234_5678_9ABC_DEF1;
    manual_frame(0, k2);
    wait_until(k2 + 82);
    read_req[0] = 1'b1;
    step();
    check_eq("trailer_req_overrun", 64'(overrun[0]), 64'd1);
    check_eq("trailer_req_busy", 64'(busy[0]), 64'd0);
    push_frame(0, cyc + 2);
    step();
    read_req[0] = 1'b0;
    check_eq("idle_req_snap", 64'(save_data[0]), 64'd1);
    wait_until(k2 + 100);
    read_req[0] = 1'b1;
    clr_overrun[0] = 1'b1;
    step();
    read_req[0] = 1'b0;
    clr_overrun[0] = 1'b0;
    check_eq("overrun_set_wins", 64'(overrun[0]), 64'd1);
    clr_overrun[0] = 1'b1;
    step();
    clr_overrun[0] = 1'b0;
    check_eq("overrun_cleared", 64'(overrun[0]), 64'd0);
    wait_until(k2 + 166);
    check_eq("back2back_busy", 64'(busy[0]), 64'd0);
    check_eq("back2back_fnum", 64'(frame_num[0]), 64'd3);

    // Reset in the middle of the payload (bit 30)
    reset_inst(0);
    check_eq("pre_abort_fnum", 64'(frame_num[0]), 64'd0);
    pattern[0] = 64'hFFFF_0000_AAAA_5555;
    k = cyc;
    read_req[0] = 1'b1;
    step();
    read_req[0] = 1'b0;
    wait_until(k + 48);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check_eq("abort_busy", 64'(busy[0]), 64'd0);
    check_eq("abort_tx_valid", 64'(tx_valid[0]), 64'd0);
    check_eq("abort_tx_data", 64'(tx_data[0]), 64'd0);
    check_eq("abort_ser_rst", 64'(ser_rst[0]), 64'd1);
    check_eq("abort_frame_end", 64'(frame_end[0]), 64'd0);
    check_eq("abort_fnum", 64'(frame_num[0]), 64'd0);
    manual_frame(0, k);
    wait_until(k + 83);

    // Periodic readout every 200 cycles
    reset_inst(0);
    pattern[0] = 64'h0F0F_F0F0_1111_8888;
    interval[0] = 24'd200;
    enable[0] = 1'b1;
    k = cyc;
    for (int i = 0; i < 5; i++) push_frame(0, k + 201 + 200 * i);
    wait_until(k + 1000);
    enable[0] = 1'b0;
    wait_until(k + 1085);
    check_eq("periodic_overrun", 64'(overrun[0]), 64'd0);
    check_eq("periodic_fnum", 64'(frame_num[0]), 64'd5);

    // READ_REQ coincident with a tick gives a single frame
    enable[0] = 1'b1;
    k = cyc;
    wait_until(k + 199);
    read_req[0] = 1'b1;
    push_frame(0, cyc + 2);
    step();
    read_req[0] = 1'b0;
    enable[0] = 1'b0;
    wait_until(k + 283);
    check_eq("coincident_overrun", 64'(overrun[0]), 64'd0);
    check_eq("coincident_fnum", 64'(frame_num[0]), 64'd6);

    // Interval shorter than a frame
    interval[0] = 24'd50;
    enable[0] = 1'b1;
    k = cyc;
    push_frame(0, k + 51);
    push_frame(0, k + 151);
    wait_until(k + 99);
    check_eq("ovr_before_tick2", 64'(overrun[0]), 64'd0);
    step();
    check_eq("ovr_after_tick2", 64'(overrun[0]), 64'd1);
    wait_until(k + 150);
    enable[0] = 1'b0;
    step();
    clr_overrun[0] = 1'b1;
    step();
    clr_overrun[0] = 1'b0;
    check_eq("ovr_clear", 64'(overrun[0]), 64'd0);
    wait_until(k + 233);
    check_eq("ovr_busy_done", 64'(busy[0]), 64'd0);

    // Serializer latency 3, odd-weight payload
    pattern[1] = 64'hDEAD_BEEF_0123_4566;
    manual_frame(1, k);
    wait_until(k + 14);
    check_eq("lat3_ser_rst_hi", 64'(ser_rst[1]), 64'd1);
    step();
    check_eq("lat3_ser_rst_lo", 64'(ser_rst[1]), 64'd0);
    wait_until(k + 82);
    check_eq("lat3_trailer_bit", 64'(tx_data[1]), 64'd1);
    wait_until(k + 83);
    check_eq("lat3_fnum", 64'(frame_num[1]), 64'd1);

    // Frame number wrap
    n = 256 - int'(fn_model[0]);
    for (int j = 0; j < n; j++) begin
      if (j == n - 1) check_eq("fnum_255", 64'(frame_num[0]), 64'd255);
      pattern[0] = {$urandom, $urandom};
      manual_frame(0, k);
      wait_until(k + 83);
    end
    check_eq("fnum_wrap", 64'(frame_num[0]), 64'd0);

    step();
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_readout_sequencer.md
Name: shift_readout_sequencer

Overview:
- Schedules and frames readout of the shift-chain error counters.
- On a manual request or a programmable periodic tick, it pulses the snapshot strobe to the counter serializer and releases the serializer from reset at a fixed offset.
- It emits one framed bitstream on TX_DATA/TX_VALID: a sync/frame-number header, the serialized payload, and an even-parity trailer bit.
- It sits between the error-counter serializer and the off-chip data link.

Parameters:
NUM_CHAINS, 4, number of chains serialized per frame
CNT_WIDTH, 16, bits per chain counter; payload length PAY_LEN = NUM_CHAINS*CNT_WIDTH (64)
SYNC_WORD, 8'hA5, header sync byte
SER_LATENCY, 1, DATA_CLK cycles from SER_RST low to first valid payload bit on SER_DATA; legal range 1..16
INT_WIDTH, 24, width of INTERVAL

Ports:
DATA_CLK  in  1  clock
RST  in  1  synchronous, active-high reset
ENABLE  in  1  enables periodic readout
INTERVAL  in  INT_WIDTH  period in cycles between auto triggers; 0 = manual only
READ_REQ  in  1  one-cycle manual readout request
CLR_OVERRUN  in  1  clears OVERRUN
SER_DATA  in  1  serial payload bit from counter serializer
SAVE_DATA  out  1  one-cycle snapshot strobe to serializer
SER_RST  out  1  serializer reset, high except during payload readout
TX_DATA  out  1  framed serial data
TX_VALID  out  1  TX_DATA valid
FRAME_START  out  1  high on first header cycle
FRAME_END  out  1  high on trailer cycle
BUSY  out  1  high from SNAP through TRAILER
FRAME_NUM  out  8  count of completed frames, wraps 255->0
OVERRUN  out  1  sticky: a trigger was dropped while BUSY

Behaviour:
- Reset (synchronous, active-high, wins over everything, may occur mid-frame):
  - Outputs: SAVE_DATA=0, SER_RST=1, TX_DATA=0, TX_VALID=0, FRAME_START=0, FRAME_END=0, BUSY=0, FRAME_NUM=0, OVERRUN=0.
  - State returns to IDLE. Interval counter and parity are cleared.
  - A frame interrupted by reset is abandoned with no trailer, and FRAME_NUM is not incremented.
- Interval counter:
  - Counts every cycle while ENABLE=1 and INTERVAL!=0, in all states.
  - On reaching INTERVAL-1 it wraps to 0 and produces a one-cycle tick.
  - ENABLE=0 or INTERVAL=0 holds the counter at 0.
  - A change of INTERVAL takes effect at the next compare.
- Trigger = READ_REQ | tick.
  - In IDLE, a trigger moves the state to SNAP. Simultaneous READ_REQ and tick produce a single frame.
  - When not IDLE, a trigger is dropped and OVERRUN is set.
  - CLR_OVERRUN clears OVERRUN. Set wins if both occur in the same cycle.
- FSM states: IDLE -> SNAP (1 cycle) -> HEADER (16 cycles) -> PAYLOAD (PAY_LEN cycles) -> TRAILER (1 cycle) -> IDLE. A 5-bit and a 7-bit down-counter, or one shared counter, track the header and payload positions.
- Timing relative to trigger sampled at edge t:
  - Cycle t+1, SNAP: SAVE_DATA=1, SER_RST=1, BUSY=1, TX_VALID=0.
  - Cycles t+2..t+17, HEADER: TX_VALID=1. TX_DATA = {SYNC_WORD, FRAME_NUM}, MSB first. FRAME_NUM is captured at SNAP. FRAME_START=1 on t+2.
  - SER_RST drops low on cycle t+18-SER_LATENCY and stays low through the last PAYLOAD cycle.
  - Cycles t+18..t+17+PAY_LEN, PAYLOAD: TX_DATA = SER_DATA on the same cycle (combinational pass-through, no reordering). Parity accumulates the XOR of SER_DATA.
  - Cycle t+18+PAY_LEN, TRAILER: TX_DATA = parity (even parity over payload, so 1 if the payload has an odd count of ones). FRAME_END=1, SER_RST=1, and FRAME_NUM increments at the end of the cycle.
  - The next cycle is IDLE with BUSY=0 and TX_VALID=0. A trigger in this first IDLE cycle is accepted.
- Frame length is 17+PAY_LEN+1 cycles including SNAP (82 at defaults). Minimum trigger spacing is therefore 83 cycles. Any INTERVAL<83 causes OVERRUN on the intermediate ticks.
- Outside HEADER/PAYLOAD/TRAILER: TX_DATA=0 and TX_VALID=0.

Test Plan:
- Manual frame: RST 2 cycles, READ_REQ pulse; serializer model drives 64'h0001_8000_FFFF_00F0. Required: SAVE_DATA one cycle later; 16 header bits 0xA5,0x00; 64 payload bits matching the model; trailer parity 0; FRAME_NUM=1; BUSY low after 82 cycles.
- Periodic: ENABLE=1, INTERVAL=200, run 1000 cycles. Required: frames start every 200 cycles (5 frames), header frame numbers 0..4, OVERRUN stays 0.
- Overrun: INTERVAL=50. Required: OVERRUN sets on the second tick, the dropped tick produces no frame, and the next frame starts on the first tick after BUSY falls. CLR_OVERRUN pulse clears it. Repeat with CLR_OVERRUN coincident with a drop: OVERRUN stays 1.
- Simultaneous READ_REQ and tick in IDLE: exactly one frame and no OVERRUN. READ_REQ on the TRAILER cycle sets OVERRUN; READ_REQ on the first IDLE cycle starts a frame.
- Reset mid-PAYLOAD (bit 30): on the next cycle all outputs are at reset values and SER_RST=1; FRAME_NUM is unchanged at 0; the subsequent READ_REQ frame has header frame number 0.
- SER_LATENCY=3 build: SER_RST falls at t+15; payload alignment and parity are correct for an odd-weight pattern (trailer=1). FRAME_NUM wrap is checked at 255->0 after 256 frames.
